// File: rtl/llc_req_arbiter.sv
// Two-way round-robin merge of L2 and DMA requests into one registered LLC request slot.
// A multi-beat DMA write burst can optionally hold the grant until its final beat.
`ifndef MIX_MSG_TYPE_WIDTH
`define MIX_MSG_TYPE_WIDTH 5
`endif
`ifndef HPROT_WIDTH
`define HPROT_WIDTH 2
`endif
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 26
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif
`ifndef CACHE_ID_WIDTH
`define CACHE_ID_WIDTH 2
`endif
`ifndef WORD_BITS
`define WORD_BITS 2
`endif
`ifndef LLC_COH_DEV_ID_WIDTH
`define LLC_COH_DEV_ID_WIDTH 4
`endif
`ifndef REQ_DMA_WRITE
`define REQ_DMA_WRITE 5'd7
`endif

module llc_req_arbiter #(
    parameter bit DMA_BURST_LOCK = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             l2_req_valid,
    output logic                             l2_req_ready,
    input  logic [`MIX_MSG_TYPE_WIDTH-1:0]   l2_req_coh_msg,
    input  logic [`HPROT_WIDTH-1:0]          l2_req_hprot,
    input  logic [`LINE_ADDR_BITS-1:0]       l2_req_addr,
    input  logic [`BITS_PER_LINE-1:0]        l2_req_line,
    input  logic [`CACHE_ID_WIDTH-1:0]       l2_req_req_id,
    input  logic [`WORD_BITS-1:0]            l2_req_word_offset,
    input  logic [`WORD_BITS-1:0]            l2_req_valid_words,
    input  logic                             dma_req_valid,
    output logic                             dma_req_ready,
    input  logic [`MIX_MSG_TYPE_WIDTH-1:0]   dma_req_coh_msg,
    input  logic [`HPROT_WIDTH-1:0]          dma_req_hprot,
    input  logic [`LINE_ADDR_BITS-1:0]       dma_req_addr,
    input  logic [`BITS_PER_LINE-1:0]        dma_req_line,
    input  logic [`LLC_COH_DEV_ID_WIDTH-1:0] dma_req_req_id,
    input  logic [`WORD_BITS-1:0]            dma_req_word_offset,
    input  logic [`WORD_BITS-1:0]            dma_req_valid_words,
    output logic                             llc_req_valid,
    input  logic                             llc_req_ready,
    output logic [`MIX_MSG_TYPE_WIDTH-1:0]   llc_req_coh_msg,
    output logic [`HPROT_WIDTH-1:0]          llc_req_hprot,
    output logic [`LINE_ADDR_BITS-1:0]       llc_req_addr,
    output logic [`BITS_PER_LINE-1:0]        llc_req_line,
    output logic [`LLC_COH_DEV_ID_WIDTH-1:0] llc_req_req_id,
    output logic [`WORD_BITS-1:0]            llc_req_word_offset,
    output logic [`WORD_BITS-1:0]            llc_req_valid_words,
    output logic                             llc_req_is_dma,
    output logic                             dma_locked
);

    localparam int DW = `LLC_COH_DEV_ID_WIDTH;

    typedef enum logic {ARB, DMA_LOCK} state_t;

    state_t state, state_next;
    logic   last_grant;   // 1 = DMA won the last accepted transfer
    logic   grant_l2, grant_dma;
    logic   load_en, l2_xfer, dma_xfer, burst_start;

    assign load_en = !llc_req_valid || llc_req_ready;
    // Readies are forced low while reset is held, independent of input valids.
    assign l2_req_ready  = grant_l2 && load_en && rst;
    assign dma_req_ready = grant_dma && load_en && rst;
    assign l2_xfer  = l2_req_valid && l2_req_ready;
    assign dma_xfer = dma_req_valid && dma_req_ready;
    assign burst_start = (dma_req_coh_msg == `REQ_DMA_WRITE) && dma_req_hprot[0];
    assign dma_locked  = (state == DMA_LOCK);

    always_comb begin
        grant_l2  = 1'b0;
        grant_dma = 1'b0;
        if (state == DMA_LOCK) begin
            grant_dma = dma_req_valid;
        end else if (l2_req_valid && dma_req_valid) begin
            grant_l2  = last_grant;
            grant_dma = !last_grant;
        end else begin
            grant_l2  = l2_req_valid;
            grant_dma = dma_req_valid;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:      if (DMA_BURST_LOCK && dma_xfer && burst_start) state_next = DMA_LOCK;
            DMA_LOCK: if (dma_xfer && !dma_req_hprot[0]) state_next = ARB;
            default:  state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (dma_xfer)     last_grant <= 1'b1;
            else if (l2_xfer) last_grant <= 1'b0;
        end
    end

    // Single output slot; payload only changes when a new entry is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llc_req_valid       <= 1'b0;
            llc_req_coh_msg     <= '0;
            llc_req_hprot       <= '0;
            llc_req_addr        <= '0;
            llc_req_line        <= '0;
            llc_req_req_id      <= '0;
            llc_req_word_offset <= '0;
            llc_req_valid_words <= '0;
            llc_req_is_dma      <= 1'b0;
        end else if (load_en) begin
            llc_req_valid <= l2_xfer || dma_xfer;
            if (dma_xfer) begin
                llc_req_coh_msg     <= dma_req_coh_msg;
                llc_req_hprot       <= dma_req_hprot;
                llc_req_addr        <= dma_req_addr;
                llc_req_line        <= dma_req_line;
                llc_req_req_id      <= dma_req_req_id;
                llc_req_word_offset <= dma_req_word_offset;
                llc_req_valid_words <= dma_req_valid_words;
                llc_req_is_dma      <= 1'b1;
            end else if (l2_xfer) begin
                llc_req_coh_msg     <= l2_req_coh_msg;
                llc_req_hprot       <= l2_req_hprot;
                llc_req_addr        <= l2_req_addr;
                llc_req_line        <= l2_req_line;
                llc_req_req_id      <= DW'(l2_req_req_id);
                llc_req_word_offset <= l2_req_word_offset;
                llc_req_valid_words <= l2_req_valid_words;
                llc_req_is_dma      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Bench for llc_req_arbiter: one instance with burst lock, one without, sharing a reference model.
`ifndef MIX_MSG_TYPE_WIDTH
`define MIX_MSG_TYPE_WIDTH 5
`endif
`ifndef HPROT_WIDTH
`define HPROT_WIDTH 2
`endif
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 26
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif
`ifndef CACHE_ID_WIDTH
`define CACHE_ID_WIDTH 2
`endif
`ifndef WORD_BITS
`define WORD_BITS 2
`endif
`ifndef LLC_COH_DEV_ID_WIDTH
`define LLC_COH_DEV_ID_WIDTH 4
`endif
`ifndef REQ_DMA_WRITE
`define REQ_DMA_WRITE 5'd7
`endif

module tb_llc_req_arbiter;

    localparam int MW = `MIX_MSG_TYPE_WIDTH;
    localparam int HW = `HPROT_WIDTH;
    localparam int AW = `LINE_ADDR_BITS;
    localparam int LW = `BITS_PER_LINE;
    localparam int CW = `CACHE_ID_WIDTH;
    localparam int WB = `WORD_BITS;
    localparam int DW = `LLC_COH_DEV_ID_WIDTH;
    localparam logic [MW-1:0] WR = `REQ_DMA_WRITE;
    localparam logic [MW-1:0] RD = MW'(6);

    typedef struct packed {
        logic          l2_v;
        logic [MW-1:0] l2_msg;
        logic [HW-1:0] l2_hprot;
        logic [AW-1:0] l2_addr;
        logic [LW-1:0] l2_line;
        logic [CW-1:0] l2_id;
        logic [WB-1:0] l2_wo;
        logic [WB-1:0] l2_vw;
        logic          dma_v;
        logic [MW-1:0] dma_msg;
        logic [HW-1:0] dma_hprot;
        logic [AW-1:0] dma_addr;
        logic [LW-1:0] dma_line;
        logic [DW-1:0] dma_id;
        logic [WB-1:0] dma_wo;
        logic [WB-1:0] dma_vw;
        logic          llc_rdy;
    } in_t;

    typedef struct packed {
        logic          l2_rdy;
        logic          dma_rdy;
        logic          v;
        logic [MW-1:0] msg;
        logic [HW-1:0] hprot;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        logic [DW-1:0] id;
        logic [WB-1:0] wo;
        logic [WB-1:0] vw;
        logic          is_dma;
        logic          locked;
    } out_t;

    typedef struct packed {
        logic locked;
        logic last_dma;
        out_t o;
    } ms_t;

    // inputs: l2_v dma_v dma_write hprot0 llc_rdy | expected for locking instance:
    // pre-edge l2_rdy dma_rdy, post-edge v is_dma locked | post-edge is_dma of non-locking instance
    typedef struct packed {
        logic l2_v, dma_v, wr, hp0, llc_rdy;
        logic e_l2, e_dma, e_v, e_isd, e_lk;
        logic e1_isd;
    } vec_t;

    logic clk, rst;
    in_t  stim [2];
    out_t act  [2];
    out_t pre  [2];
    ms_t  ms   [2];
    vec_t tab  [16];
    int   n_vec, n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic          l2r, dmar, v, isd, lk;
        logic [MW-1:0] msg;
        logic [HW-1:0] hp;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        logic [DW-1:0] id;
        logic [WB-1:0] wo, vw;
        llc_req_arbiter #(.DMA_BURST_LOCK(k == 0)) u_dut (
            .clk(clk), .rst(rst),
            .l2_req_valid(stim[k].l2_v), .l2_req_ready(l2r),
            .l2_req_coh_msg(stim[k].l2_msg), .l2_req_hprot(stim[k].l2_hprot),
            .l2_req_addr(stim[k].l2_addr), .l2_req_line(stim[k].l2_line),
            .l2_req_req_id(stim[k].l2_id), .l2_req_word_offset(stim[k].l2_wo),
            .l2_req_valid_words(stim[k].l2_vw),
            .dma_req_valid(stim[k].dma_v), .dma_req_ready(dmar),
            .dma_req_coh_msg(stim[k].dma_msg), .dma_req_hprot(stim[k].dma_hprot),
            .dma_req_addr(stim[k].dma_addr), .dma_req_line(stim[k].dma_line),
            .dma_req_req_id(stim[k].dma_id), .dma_req_word_offset(stim[k].dma_wo),
            .dma_req_valid_words(stim[k].dma_vw),
            .llc_req_valid(v), .llc_req_ready(stim[k].llc_rdy),
            .llc_req_coh_msg(msg), .llc_req_hprot(hp), .llc_req_addr(addr),
            .llc_req_line(line), .llc_req_req_id(id), .llc_req_word_offset(wo),
            .llc_req_valid_words(vw), .llc_req_is_dma(isd), .dma_locked(lk)
        );
        assign act[k] = {l2r, dmar, v, msg, hp, addr, line, id, wo, vw, isd, lk};
    end

    function automatic ms_t mreset();
        ms_t s;
        s = '0;
        s.last_dma = 1'b1;
        return s;
    endfunction

    // Expected visible outputs: registered slot plus which requester is offered the slot now.
    function automatic out_t mout(ms_t s, in_t i, logic rn);
        out_t o;
        logic room, pick_l2, pick_dma;
        o = s.o;
        o.locked = s.locked;
        room = !s.o.v || i.llc_rdy;
        if (s.locked) begin
            pick_l2 = 1'b0;
            pick_dma = i.dma_v;
        end else if (i.l2_v && i.dma_v) begin
            pick_l2 = s.last_dma;
            pick_dma = !s.last_dma;
        end else begin
            pick_l2 = i.l2_v;
            pick_dma = i.dma_v;
        end
        o.l2_rdy  = rn && room && pick_l2;
        o.dma_rdy = rn && room && pick_dma;
        return o;
    endfunction

    function automatic ms_t mnext(ms_t s, in_t i, logic lock_en);
        out_t o;
        ms_t  n;
        logic take_l2, take_dma;
        o = mout(s, i, 1'b1);
        n = s;
        take_l2  = o.l2_rdy && i.l2_v;
        take_dma = o.dma_rdy && i.dma_v;
        if (!s.o.v || i.llc_rdy) n.o.v = take_l2 || take_dma;
        if (take_l2) begin
            n.o.msg = i.l2_msg; n.o.hprot = i.l2_hprot; n.o.addr = i.l2_addr;
            n.o.line = i.l2_line; n.o.id = DW'(i.l2_id); n.o.wo = i.l2_wo;
            n.o.vw = i.l2_vw; n.o.is_dma = 1'b0; n.last_dma = 1'b0;
        end
        if (take_dma) begin
            n.o.msg = i.dma_msg; n.o.hprot = i.dma_hprot; n.o.addr = i.dma_addr;
            n.o.line = i.dma_line; n.o.id = i.dma_id; n.o.wo = i.dma_wo;
            n.o.vw = i.dma_vw; n.o.is_dma = 1'b1; n.last_dma = 1'b1;
            if (lock_en)
                n.locked = s.locked ? i.dma_hprot[0] : (i.dma_msg == WR && i.dma_hprot[0]);
        end
        return n;
    endfunction

    function automatic logic [LW-1:0] rline();
        logic [LW-1:0] l;
        for (int b = 0; b < LW; b += 32) l[b +: 32] = $urandom;
        return l;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.l2_v = ($urandom_range(0, 99) < 75);
        i.l2_msg = MW'($urandom); i.l2_hprot = HW'($urandom); i.l2_addr = AW'($urandom);
        i.l2_line = rline(); i.l2_id = CW'($urandom); i.l2_wo = WB'($urandom); i.l2_vw = WB'($urandom);
        i.dma_v = ($urandom_range(0, 99) < 75);
        i.dma_msg = ($urandom_range(0, 1) == 1) ? WR : MW'($urandom);
        i.dma_hprot = HW'($urandom); i.dma_addr = AW'($urandom); i.dma_line = rline();
        i.dma_id = DW'($urandom); i.dma_wo = WB'($urandom); i.dma_vw = WB'($urandom);
        i.llc_rdy = ($urandom_range(0, 99) < 70);
        return i;
    endfunction

    function automatic in_t row_in(vec_t t, int r);
        in_t i;
        i = '0;
        i.l2_v = t.l2_v; i.dma_v = t.dma_v; i.llc_rdy = t.llc_rdy;
        i.l2_msg = MW'(r); i.l2_hprot = HW'(r); i.l2_addr = AW'(r * 16 + 1);
        i.l2_line = rline(); i.l2_id = (r == 0) ? CW'(3) : CW'(r); i.l2_wo = WB'(r); i.l2_vw = WB'(r + 1);
        i.dma_msg = t.wr ? WR : RD; i.dma_hprot = {1'b1, t.hp0}; i.dma_addr = AW'(r * 16 + 2);
        i.dma_line = rline(); i.dma_id = DW'(r + 8); i.dma_wo = WB'(r + 2); i.dma_vw = WB'(r + 3);
        return i;
    endfunction

    task automatic chk(string name, logic got, logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    // Compare both instances against the model before the edge, then advance the model.
    task automatic cycle();
        out_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = mout(ms[k], stim[k], rst);
            pre[k] = act[k];
            n_vec++;
            if (act[k] !== e) begin
                n_err++;
                $display("FAIL model inst=%0d t=%0t got=%h exp=%h", k, $time, act[k], e);
            end
            ms[k] = rst ? mnext(ms[k], stim[k], k == 0) : mreset();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        tab[0] = 11'b11001_10100_0;
        tab[1] = 11'b11001_01110_1;
        tab[2] = 11'b11001_10100_0;
        tab[3] = 11'b11001_01110_1;
        tab[4] = 11'b11111_10100_0;
        tab[5] = 11'b11111_01111_1;
        tab[6] = 11'b11111_01111_0;
        tab[7] = 11'b11111_01111_1;
        tab[8] = 11'b11101_01110_0;
        tab[9] = 11'b10001_10100_0;
        for (int r = 10; r < 15; r++) tab[r] = 11'b11000_00100_0;
        tab[15] = 11'b11001_01110_1;

        // Reset with both requesters valid: nothing may be accepted.
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ms[k] = mreset();
            stim[k] = rand_in();
            stim[k].l2_v = 1'b1; stim[k].dma_v = 1'b1; stim[k].llc_rdy = 1'b1;
        end
        repeat (3) cycle();
        chk("rst_l2_ready", pre[0].l2_rdy, 1'b0);
        chk("rst_dma_ready", pre[0].dma_rdy, 1'b0);
        chk("rst_valid", act[0].v, 1'b0);
        chk("rst_locked", act[0].locked, 1'b0);

        rst = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 2; k++) stim[k] = row_in(tab[r], r);
            cycle();
            chk($sformatf("tab%0d_l2_ready", r), pre[0].l2_rdy, tab[r].e_l2);
            chk($sformatf("tab%0d_dma_ready", r), pre[0].dma_rdy, tab[r].e_dma);
            chk($sformatf("tab%0d_valid", r), act[0].v, tab[r].e_v);
            chk($sformatf("tab%0d_is_dma", r), act[0].is_dma, tab[r].e_isd);
            chk($sformatf("tab%0d_locked", r), act[0].locked, tab[r].e_lk);
            chk($sformatf("tab%0d_nolock_is_dma", r), act[1].is_dma, tab[r].e1_isd);
            chk($sformatf("tab%0d_nolock_locked", r), act[1].locked, 1'b0);
            if (r == 0) begin
                n_vec++;
                if (act[0].id !== DW'(3)) begin
                    n_err++;
                    $display("FAIL l2_id_zext got=%h exp=%h", act[0].id, DW'(3));
                end
            end
        end

        // Enter a lock with a valid entry held, then reset asynchronously mid-burst.
        for (int k = 0; k < 2; k++) begin
            stim[k] = row_in(11'b01111_00000_0, 20);
            stim[k].l2_v = 1'b0;
        end
        cycle();
        chk("pre_rst_locked", act[0].locked, 1'b1);
        chk("pre_rst_valid", act[0].v, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", act[0].v, 1'b0);
        chk("async_rst_locked", act[0].locked, 1'b0);
        chk("async_rst_dma_ready", act[0].dma_rdy, 1'b0);
        for (int k = 0; k < 2; k++) ms[k] = mreset();
        cycle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) stim[k] = row_in(11'b11001_00000_0, 21);
        cycle();
        chk("post_rst_l2_first", pre[0].l2_rdy, 1'b1);
        chk("post_rst_dma_wait", pre[0].dma_rdy, 1'b0);
        chk("post_rst_is_dma", act[0].is_dma, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) stim[k] = rand_in();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/llc_req_arbiter.md
LLC_REQ_ARBITER -- requirements
Module: llc_req_arbiter

Interface
REQ-001 Parameter: DMA_BURST_LOCK, 1, when 1 a granted DMA write burst holds the grant until its last beat.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 l2_req_valid / l2_req_ready  in / out  1 / 1  coherent (L2-side) request handshake.
REQ-005 l2_req_coh_msg, l2_req_hprot, l2_req_addr, l2_req_line, l2_req_req_id, l2_req_word_offset, l2_req_valid_words  in  `MIX_MSG_TYPE_WIDTH, `HPROT_WIDTH, `LINE_ADDR_BITS, `BITS_PER_LINE, `CACHE_ID_WIDTH, `WORD_BITS, `WORD_BITS  L2 request fields.
REQ-006 dma_req_valid / dma_req_ready  in / out  1 / 1  DMA request handshake.
REQ-007 dma_req_coh_msg, dma_req_hprot, dma_req_addr, dma_req_line, dma_req_req_id, dma_req_word_offset, dma_req_valid_words  in  as REQ-005, except req_id is `LLC_COH_DEV_ID_WIDTH  DMA request fields.
REQ-008 llc_req_valid / llc_req_ready  out / in  1 / 1  merged request handshake toward the LLC.
REQ-009 llc_req_coh_msg, _hprot, _addr, _line, _word_offset, _valid_words  out  as REQ-005  registered merged fields.
REQ-010 llc_req_req_id  out  `LLC_COH_DEV_ID_WIDTH  requester ID; L2 IDs are zero-extended.
REQ-011 llc_req_is_dma  out  1  1 = entry came from the DMA port.
REQ-012 dma_locked  out  1  a DMA write burst currently owns the arbiter.

Function
REQ-013 Transfer on any port SHALL occur only in a cycle where valid and ready are both 1.
REQ-014 The output SHALL be a one-entry pipeline register: load_en = !llc_req_valid || llc_req_ready.
REQ-015 l2_req_ready SHALL equal grant_l2 && load_en.
REQ-016 dma_req_ready SHALL equal grant_dma && load_en.
REQ-017 Latency: the accepted request appears on llc_req_* the next cycle, with sustained throughput of one request per cycle.
REQ-018 Ready signals SHALL depend only on registered state, the input valid signals and llc_req_ready; they SHALL NOT depend on input payload.
REQ-019 Arbitration SHALL be two-way round-robin with a last_grant bit.
REQ-020 When both valid and unlocked, the port not in last_grant SHALL win.
REQ-021 When only one port is valid, that port SHALL win.
REQ-022 last_grant SHALL update only on an accepted transfer.
REQ-023 The FSM SHALL have two states: ARB and DMA_LOCK.
REQ-024 ARB -> DMA_LOCK on an accepted DMA beat with coh_msg == `REQ_DMA_WRITE, hprot[0] == 1 and DMA_BURST_LOCK == 1.
REQ-025 In DMA_LOCK only the DMA port SHALL be granted, and l2_req_ready SHALL be 0.
REQ-026 DMA_LOCK -> ARB on an accepted DMA beat with hprot[0] == 0 (burst end).
REQ-027 A single-beat write (hprot[0] == 0 on the first beat) SHALL NOT enter DMA_LOCK.
REQ-028 DMA reads and all L2 messages SHALL never lock.
REQ-029 dma_locked SHALL equal (state == DMA_LOCK).
REQ-030 Output register SHALL hold its value unchanged while llc_req_valid && !llc_req_ready.
REQ-031 With DMA_BURST_LOCK == 0, the FSM SHALL stay in ARB permanently.

Reset
REQ-032 While rst is low: state = ARB, last_grant = DMA (so L2 wins the first tie), llc_req_valid = 0, all llc_req_* payload = 0, llc_req_is_dma = 0, dma_locked = 0.
REQ-033 Both ready outputs SHALL be 0 during reset.
REQ-034 Assertion mid-burst or mid-transfer SHALL discard the registered entry and the lock immediately, with no partial output.

Verification
REQ-035 Both ports are valid continuously and llc_req_ready = 1 -> outputs alternate L2, DMA, L2, DMA, starting with L2 after reset, one per cycle.
REQ-036 DMA write burst of 4 beats (hprot[0] = 1, 1, 1, 0) with L2 valid throughout -> 4 consecutive DMA entries, dma_locked = 1 for 3 cycles, then L2 is granted next.
REQ-037 llc_req_ready held 0 for 5 cycles with a pending entry -> payload stable, both input readys 0; on release, next entry 1 cycle later.
REQ-038 L2 req_id = 3 -> llc_req_req_id = 3 zero-extended, llc_req_is_dma = 0.
REQ-039 rst asserted while in DMA_LOCK with llc_req_valid = 1 -> llc_req_valid = 0 and dma_locked = 0 immediately; L2 granted first after release.
REQ-040 DMA_BURST_LOCK = 0 with the same burst as REQ-036 -> L2 and DMA interleave, dma_locked stays 0.
